// File: rtl/w_control_pkg.sv
//------------------------------------------------------------------------------
// Module : w_control_pkg
// Brief  : RV32I opcode, CSR funct3 and writeback-select encodings shared by
//          the writeback control decode.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package w_control_pkg;

   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_OP     = 7'b0110011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] c_F3_CSRRW  = 3'b001;
   localparam logic [2:0] c_F3_CSRRWI = 3'b101;

   // 2'b11 is reserved and never produced by the decode.
   typedef enum logic [1:0] {
      c_WB_MEM = 2'b00,
      c_WB_ALU = 2'b01,
      c_WB_PC4 = 2'b10
   } wb_sel_e;

   function automatic logic is_csr_write(input logic [2:0] funct3);
      return (funct3 == c_F3_CSRRW) || (funct3 == c_F3_CSRRWI);
   endfunction

endpackage

`default_nettype wire

// File: rtl/w_control.sv
//------------------------------------------------------------------------------
// Module : w_control
// Brief  : Combinational writeback-stage control: writeback mux select,
//          register-file write enable and CSR write enable from opcode/funct3.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module w_control
   import w_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output logic [1:0] wb_sel,
   output logic       rwe,
   output logic       csr_we
);

   wb_sel_e w_wb_sel;
   logic    w_rwe;
   logic    w_csr_we;

   // clk/rst exist only for pipeline uniformity; reset-time write suppression
   // comes from upstream bubbles, so neither reaches the decode.
   logic    w_unused_clk_rst;
   assign w_unused_clk_rst = clk ^ rst;

   always_comb begin
      w_wb_sel = c_WB_ALU;
      w_rwe    = 1'b0;
      w_csr_we = 1'b0;
      case (opcode)
         c_OP_LOAD: begin
            w_wb_sel = c_WB_MEM;
            w_rwe    = 1'b1;
         end
         c_OP_OP, c_OP_IMM, c_OP_LUI, c_OP_AUIPC: begin
            w_rwe    = 1'b1;
         end
         c_OP_JAL, c_OP_JALR: begin
            w_wb_sel = c_WB_PC4;
            w_rwe    = 1'b1;
         end
         c_OP_SYSTEM: begin
            w_csr_we = is_csr_write(funct3);
         end
         c_OP_STORE, c_OP_BRANCH: begin
            w_rwe    = 1'b0;
         end
         default: begin
            w_wb_sel = c_WB_ALU;
            w_rwe    = 1'b0;
            w_csr_we = 1'b0;
         end
      endcase
   end

   assign wb_sel = w_wb_sel;
   assign rwe    = w_rwe;
   assign csr_we = w_csr_we;

endmodule

`default_nettype wire

// File: tb/tb_w_control.sv
//------------------------------------------------------------------------------
// Module : tb_w_control
// Brief  : Self-checking bench for w_control against a rule-level reference.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_w_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic [1:0] wb_sel;
   logic       rwe;
   logic       csr_we;

   int n_vec = 0;
   int n_err = 0;

   w_control dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .funct3 (funct3),
      .wb_sel (wb_sel),
      .rwe    (rwe),
      .csr_we (csr_we)
   );

   always #5 clk = ~clk;

   // Reference: {wb_sel, rwe, csr_we} from the instruction-class rules.
   function automatic logic [3:0] model(input logic [6:0] op, input logic [2:0] f3);
      if (op == 7'b0000011)                                       return 4'b00_1_0;
      if (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111}) return 4'b01_1_0;
      if (op inside {7'b1101111, 7'b1100111})                     return 4'b10_1_0;
      if (op == 7'b1110011 && (f3 == 3'd1 || f3 == 3'd5))         return 4'b01_0_1;
      return 4'b01_0_0;
   endfunction

   // Stimulus at negedge, sampled one fifth of a period (2 ns) later.
   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic r);
      @(negedge clk);
      opcode = op;
      funct3 = f3;
      rst    = r;
      #2;
      n_vec++;
   endtask

   task automatic test_reset();
      logic [3:0] e;
      drive(7'b0000011, 3'b010, 1'b1);
      e = model(7'b0000011, 3'b010);
      if ({wb_sel, rwe, csr_we} !== e) begin
         $display("FAIL reset_load: got wb_sel=%b rwe=%b csr_we=%b want %b", wb_sel, rwe, csr_we, e);
         n_err++;
      end
      drive(7'b0000000, 3'b000, 1'b1);
      if (wb_sel !== 2'b01 || rwe !== 1'b0 || csr_we !== 1'b0) begin
         $display("FAIL reset_bubble: got wb_sel=%b rwe=%b csr_we=%b want 01 0 0", wb_sel, rwe, csr_we);
         n_err++;
      end
   endtask

   task automatic test_directed();
      logic [6:0] ops [12] = '{7'b0000011, 7'b0110011, 7'b0110111, 7'b1101111,
                               7'b1100111, 7'b1110011, 7'b1110011, 7'b1110011,
                               7'b0100011, 7'b1100011, 7'b0000000, 7'b0010111};
      logic [2:0] f3s [12] = '{3'b010, 3'b000, 3'b011, 3'b110, 3'b000, 3'b001,
                               3'b101, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100};
      logic [3:0] exp [12] = '{4'b00_1_0, 4'b01_1_0, 4'b01_1_0, 4'b10_1_0,
                               4'b10_1_0, 4'b01_0_1, 4'b01_0_1, 4'b01_0_0,
                               4'b01_0_0, 4'b01_0_0, 4'b01_0_0, 4'b01_1_0};
      for (int i = 0; i < 12; i++) begin
         drive(ops[i], f3s[i], 1'b0);
         if (wb_sel !== exp[i][3:2]) begin
            $display("FAIL directed_wb_sel[%0d] op=%b f3=%b: got %b want %b", i, ops[i], f3s[i], wb_sel, exp[i][3:2]);
            n_err++;
         end
         if (rwe !== exp[i][1] || csr_we !== exp[i][0]) begin
            $display("FAIL directed_we[%0d] op=%b f3=%b: got rwe=%b csr_we=%b want %b %b",
                     i, ops[i], f3s[i], rwe, csr_we, exp[i][1], exp[i][0]);
            n_err++;
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [3:0] e;
      for (int i = 0; i < 1024; i++) begin
         drive(i[9:3], i[2:0], (i % 3) == 0);
         e = model(i[9:3], i[2:0]);
         if ($isunknown({wb_sel, rwe, csr_we})) begin
            $display("FAIL exh_unknown op=%b f3=%b: got %b%b%b want known", i[9:3], i[2:0], wb_sel, rwe, csr_we);
            n_err++;
         end else if (wb_sel !== e[3:2] || rwe !== e[1] || csr_we !== e[0]) begin
            $display("FAIL exh_decode op=%b f3=%b rst=%b: got wb_sel=%b rwe=%b csr_we=%b want %b",
                     i[9:3], i[2:0], rst, wb_sel, rwe, csr_we, e);
            n_err++;
         end
         if (rwe === 1'b1 && csr_we === 1'b1) begin
            $display("FAIL exh_both_we op=%b f3=%b: got rwe=1 csr_we=1 want not both", i[9:3], i[2:0]);
            n_err++;
         end
         if (wb_sel === 2'b11) begin
            $display("FAIL exh_wb_reserved op=%b f3=%b: got 11 want 00/01/10", i[9:3], i[2:0]);
            n_err++;
         end
      end
   endtask

   task automatic test_random();
      logic [6:0] op;
      logic [2:0] f3;
      logic [3:0] e;
      logic [6:0] hot [6] = '{7'b0000011, 7'b0110011, 7'b1101111, 7'b1110011, 7'b1100011, 7'b0010111};
      for (int i = 0; i < 300; i++) begin
         op = (i % 2 == 0) ? hot[$urandom_range(0, 5)] : 7'($urandom);
         f3 = 3'($urandom);
         drive(op, f3, 1'($urandom));
         e  = model(op, f3);
         if (wb_sel !== e[3:2] || rwe !== e[1] || csr_we !== e[0]) begin
            $display("FAIL random op=%b f3=%b: got wb_sel=%b rwe=%b csr_we=%b want %b", op, f3, wb_sel, rwe, csr_we, e);
            n_err++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_exhaustive();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
